// File: rtl/sem_cmd_feeder_pkg.sv
// Shared definitions for the SEM command feeder.
// Holds the controller state encoding, the command codes, the ASCII
// characters used to spell commands, the command lengths, and small
// helpers for length lookup and hex-to-ASCII conversion.
package sem_cmd_feeder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Command codes
  localparam logic [2:0] CODE_I = 3'd0;
  localparam logic [2:0] CODE_O = 3'd1;
  localparam logic [2:0] CODE_S = 3'd2;
  localparam logic [2:0] CODE_R = 3'd3;
  localparam logic [2:0] CODE_N = 3'd4;

  // ASCII characters
  localparam logic [7:0] ASCII_I     = 8'h49;
  localparam logic [7:0] ASCII_O     = 8'h4F;
  localparam logic [7:0] ASCII_S     = 8'h53;
  localparam logic [7:0] ASCII_R     = 8'h52;
  localparam logic [7:0] ASCII_N     = 8'h4E;
  localparam logic [7:0] ASCII_SPACE = 8'h20;

  // Command lengths in bytes, terminator included
  localparam logic [3:0] LEN_SHORT = 4'd2;
  localparam logic [3:0] LEN_INJ   = 4'd13;

  // Byte count of a command; invalid codes never reach SEND.
  function automatic logic [3:0] cmd_len(input logic [2:0] code);
    if (code == CODE_N) begin
      return LEN_INJ;
    end else if (code < CODE_N) begin
      return LEN_SHORT;
    end else begin
      return 4'd0;
    end
  endfunction

  // One upper-case hex digit.
  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    if (nib < 4'd10) begin
      return 8'h30 + {4'h0, nib};
    end else begin
      return 8'h37 + {4'h0, nib};
    end
  endfunction

  // Address nibble shown at byte position idx (positions 2..11, MSB first).
  function automatic logic [3:0] addr_nibble(input logic [39:0] addr,
                                             input logic [3:0]  idx);
    logic [3:0] nib;
    nib = 4'h0;
    for (int k = 0; k < 10; k++) begin
      if (idx == 4'(k + 2)) begin
        nib = addr[39 - 4*k -: 4];
      end
    end
    return nib;
  endfunction

endpackage

// File: rtl/sem_cmd_byte_mux.sv
// Combinational byte selector for the SEM command feeder.
// Ports:
//   code     in  3   latched command code
//   index    in  4   byte position within the command
//   addr     in  40  latched injection address
//   byte_out out 8   byte at that position (8'h00 when out of range)
module sem_cmd_byte_mux
  import sem_cmd_feeder_pkg::*;
#(
  parameter logic [7:0] TERM_CHAR = 8'h0D
) (
  input  logic [2:0]  code,
  input  logic [3:0]  index,
  input  logic [39:0] addr,
  output logic [7:0]  byte_out
);

  logic [7:0] letter;

  // Selects the byte for the current code and position.
  always_comb begin
    byte_out = 8'h00;
    letter   = 8'h00;
    case (code)
      CODE_I: letter = ASCII_I;
      CODE_O: letter = ASCII_O;
      CODE_S: letter = ASCII_S;
      CODE_R: letter = ASCII_R;
      default: letter = 8'h00;
    endcase
    if (code < CODE_N) begin
      // single letter followed by the terminator
      if (index == 4'd0) begin
        byte_out = letter;
      end else if (index == 4'd1) begin
        byte_out = TERM_CHAR;
      end else begin
        byte_out = 8'h00;
      end
    end else if (code == CODE_N) begin
      case (index)
        4'd0:    byte_out = ASCII_N;
        4'd1:    byte_out = ASCII_SPACE;
        4'd12:   byte_out = TERM_CHAR;
        default: begin
          if (index <= 4'd11) begin
            byte_out = hex_ascii(addr_nibble(addr, index));
          end else begin
            byte_out = 8'h00;
          end
        end
      endcase
    end else begin
      byte_out = 8'h00;
    end
  end

endmodule

// File: rtl/sem_cmd_feeder.sv
// SEM command feeder: accepts a command request over a READY/ACK level
// handshake, then presents the command's ASCII bytes to the SEM monitor
// receive interface one byte per MON_RXREAD pop.
// Ports:
//   CLK         in  1   clock, rising edge
//   RST_N       in  1   synchronous active-low reset
//   READY       in  1   command pending
//   ACK         out 1   command fully consumed (DONE state)
//   CMD_SEL     in  3   command code, latched on acceptance
//   INJ_ADDR    in  40  injection address, latched on acceptance
//   MON_RXREAD  in  1   monitor pop strobe
//   MON_RXEMPTY out 1   no byte presented
//   MON_RXDATA  out 8   presented byte
//   BUSY        out 1   not idle
//   CMD_ERR     out 1   one-cycle pulse for an invalid code
module sem_cmd_feeder
  import sem_cmd_feeder_pkg::*;
#(
  parameter logic [7:0] TERM_CHAR = 8'h0D
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        READY,
  output logic        ACK,
  input  logic [2:0]  CMD_SEL,
  input  logic [39:0] INJ_ADDR,
  input  logic        MON_RXREAD,
  output logic        MON_RXEMPTY,
  output logic [7:0]  MON_RXDATA,
  output logic        BUSY,
  output logic        CMD_ERR
);

  state_t      state_r;
  state_t      state_nx;
  logic [2:0]  code_r;
  logic [39:0] addr_r;
  logic [3:0]  index_r;
  logic [3:0]  len_r;
  logic [7:0]  mux_byte;

  sem_cmd_byte_mux #(
    .TERM_CHAR(TERM_CHAR)
  ) u_byte_mux (
    .code    (code_r),
    .index   (index_r),
    .addr    (addr_r),
    .byte_out(mux_byte)
  );

  // State, latched command and byte index registers.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_r <= ST_IDLE;
      code_r  <= 3'd0;
      addr_r  <= 40'd0;
      index_r <= 4'd0;
      len_r   <= 4'd0;
    end else begin
      state_r <= state_nx;
      if (state_r == ST_IDLE && READY) begin
        code_r <= CMD_SEL;
        addr_r <= INJ_ADDR;
      end
      if (state_r == ST_LOAD) begin
        index_r <= 4'd0;
        len_r   <= cmd_len(code_r);
      end else if (state_r == ST_SEND && MON_RXREAD) begin
        index_r <= index_r + 4'd1;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx = state_r;
    case (state_r)
      ST_IDLE: begin
        if (READY) state_nx = ST_LOAD;
        else       state_nx = ST_IDLE;
      end
      ST_LOAD: begin
        // invalid codes skip SEND entirely
        if (code_r <= CODE_N) state_nx = ST_SEND;
        else                  state_nx = ST_DONE;
      end
      ST_SEND: begin
        if (MON_RXREAD && index_r == len_r - 4'd1) state_nx = ST_DONE;
        else                                       state_nx = ST_SEND;
      end
      ST_DONE: begin
        // READY changes while busy are ignored; only DONE looks for the drop
        if (!READY) state_nx = ST_IDLE;
        else        state_nx = ST_DONE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Outputs decoded from the registered state and index.
  always_comb begin
    BUSY        = (state_r != ST_IDLE);
    ACK         = (state_r == ST_DONE);
    CMD_ERR     = (state_r == ST_LOAD) && (code_r > CODE_N);
    MON_RXEMPTY = (state_r != ST_SEND);
    if (state_r == ST_SEND) begin
      MON_RXDATA = mux_byte;
    end else begin
      MON_RXDATA = 8'h00;
    end
  end

endmodule

// File: tb/tb_sem_cmd_feeder.sv
module tb_sem_cmd_feeder;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        READY = 1'b0;
  logic        ACK;
  logic [2:0]  CMD_SEL = 3'd0;
  logic [39:0] INJ_ADDR = 40'd0;
  logic        MON_RXREAD = 1'b0;
  logic        MON_RXEMPTY;
  logic [7:0]  MON_RXDATA;
  logic        BUSY;
  logic        CMD_ERR;

  int n_checks = 0;
  int n_fail   = 0;

  // observations collected by drive_cmd
  logic [7:0] got[$];
  logic [7:0] exp[$];
  int ack_cycles, err_pulses, err_cyc, first_ack_cyc, last_pop_cyc;
  int nonempty_cnt;
  bit timeout, busy_exit;

  sem_cmd_feeder #(.TERM_CHAR(8'h0D)) dut (
    .CLK(CLK), .RST_N(RST_N), .READY(READY), .ACK(ACK),
    .CMD_SEL(CMD_SEL), .INJ_ADDR(INJ_ADDR), .MON_RXREAD(MON_RXREAD),
    .MON_RXEMPTY(MON_RXEMPTY), .MON_RXDATA(MON_RXDATA),
    .BUSY(BUSY), .CMD_ERR(CMD_ERR)
  );

  always #5 CLK = ~CLK;

  // Reference model: the command as an ASCII string plus terminator.
  task automatic build_expected(input logic [2:0] code, input logic [39:0] addr);
    string s;
    logic [7:0] c;
    exp.delete();
    case (code)
      3'd0: s = "I";
      3'd1: s = "O";
      3'd2: s = "S";
      3'd3: s = "R";
      3'd4: s = {"N ", $sformatf("%010h", addr)};
      default: s = "";
    endcase
    for (int i = 0; i < s.len(); i++) begin
      c = s[i];
      if (c >= 8'h61 && c <= 8'h66) c = c - 8'h20;
      exp.push_back(c);
    end
    if (code <= 3'd4) exp.push_back(8'h0D);
  endtask

  // Issues one command starting at a negedge and records what the DUT does.
  // Returns at the negedge where the DUT is idle again (or after abort/timeout).
  task automatic drive_cmd(input logic [2:0] code, input logic [39:0] addr,
                           input int period, input bit hold_read,
                           input bit drop_early, input int extra_ready,
                           input int abort_after);
    int cyc;
    int ack_left;
    got.delete();
    ack_cycles = 0; err_pulses = 0; err_cyc = -1; first_ack_cyc = -1;
    last_pop_cyc = -1; nonempty_cnt = 0; timeout = 1'b0; busy_exit = 1'b1;
    READY = 1'b1; CMD_SEL = code; INJ_ADDR = addr; MON_RXREAD = hold_read;
    cyc = 0; ack_left = extra_ready;
    forever begin
      @(negedge CLK);
      cyc++;
      if (cyc == 1) begin
        CMD_SEL  = 3'($urandom);
        INJ_ADDR = {8'($urandom), 32'($urandom)};
        if (drop_early) READY = 1'b0;
      end
      if (CMD_ERR) begin err_pulses++; err_cyc = cyc; end
      if (ACK) begin
        ack_cycles++;
        if (first_ack_cyc < 0) first_ack_cyc = cyc;
      end
      if (!MON_RXEMPTY) nonempty_cnt++;
      if (abort_after > 0 && got.size() == abort_after) begin
        MON_RXREAD = 1'b0; READY = 1'b0;
        return;
      end
      if (!MON_RXEMPTY && (hold_read || (cyc % period) == 0)) begin
        got.push_back(MON_RXDATA);
        last_pop_cyc = cyc;
        MON_RXREAD = 1'b1;
      end else begin
        MON_RXREAD = hold_read;
      end
      if (ACK) begin
        if (ack_left == 0) READY = 1'b0;
        else ack_left--;
      end
      if (!ACK && first_ack_cyc >= 0) begin
        busy_exit = BUSY;
        return;
      end
      if (cyc > 200) begin
        timeout = 1'b1;
        READY = 1'b0; MON_RXREAD = 1'b0;
        return;
      end
    end
  endtask

  task automatic test_reset();
    RST_N = 1'b0; READY = 1'b1; MON_RXREAD = 1'b1; CMD_SEL = 3'd4;
    repeat (2) @(negedge CLK);
    n_checks++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", BUSY); end
    n_checks++; if (ACK !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b expected 0", ACK); end
    n_checks++; if (CMD_ERR !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", CMD_ERR); end
    n_checks++; if (MON_RXEMPTY !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b expected 1", MON_RXEMPTY); end
    n_checks++; if (MON_RXDATA !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h expected 00", MON_RXDATA); end
    READY = 1'b0; MON_RXREAD = 1'b0; RST_N = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_status_cmd();
    build_expected(3'd2, 40'd0);
    drive_cmd(3'd2, 40'd0, 3, 1'b0, 1'b0, 2, 0);
    n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL status_timeout: got %b expected 0", timeout); end
    n_checks++; if (got.size() !== exp.size()) begin n_fail++; $display("FAIL status_len: got %0d expected %0d", got.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      n_checks++; if (got[i] !== exp[i]) begin n_fail++; $display("FAIL status_byte%0d: got %h expected %h", i, got[i], exp[i]); end
    end
    n_checks++; if (first_ack_cyc - last_pop_cyc !== 1) begin n_fail++; $display("FAIL status_ack_gap: got %0d expected 1", first_ack_cyc - last_pop_cyc); end
    n_checks++; if (ack_cycles !== 3) begin n_fail++; $display("FAIL status_ack_cycles: got %0d expected 3", ack_cycles); end
    n_checks++; if (busy_exit !== 1'b0) begin n_fail++; $display("FAIL status_idle_after: got %b expected 0", busy_exit); end
  endtask

  task automatic test_inject();
    build_expected(3'd4, 40'hC00A098000);
    drive_cmd(3'd4, 40'hC00A098000, 1, 1'b0, 1'b0, 0, 0);
    n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL inject_timeout: got %b expected 0", timeout); end
    n_checks++; if (got.size() !== 13) begin n_fail++; $display("FAIL inject_len: got %0d expected 13", got.size()); end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      n_checks++; if (got[i] !== exp[i]) begin n_fail++; $display("FAIL inject_byte%0d: got %h expected %h", i, got[i], exp[i]); end
    end
    n_checks++; if (ack_cycles !== 1) begin n_fail++; $display("FAIL inject_ack_cycles: got %0d expected 1", ack_cycles); end
    n_checks++; if (first_ack_cyc - last_pop_cyc !== 1) begin n_fail++; $display("FAIL inject_ack_gap: got %0d expected 1", first_ack_cyc - last_pop_cyc); end
  endtask

  task automatic test_invalid();
    drive_cmd(3'd6, 40'h12345, 1, 1'b0, 1'b0, 0, 0);
    n_checks++; if (err_pulses !== 1) begin n_fail++; $display("FAIL invalid_err_pulses: got %0d expected 1", err_pulses); end
    n_checks++; if (err_cyc !== 1) begin n_fail++; $display("FAIL invalid_err_cycle: got %0d expected 1", err_cyc); end
    n_checks++; if (nonempty_cnt !== 0) begin n_fail++; $display("FAIL invalid_nonempty: got %0d expected 0", nonempty_cnt); end
    n_checks++; if (first_ack_cyc !== 2) begin n_fail++; $display("FAIL invalid_ack_cycle: got %0d expected 2", first_ack_cyc); end
    n_checks++; if (ack_cycles !== 1) begin n_fail++; $display("FAIL invalid_ack_cycles: got %0d expected 1", ack_cycles); end
  endtask

  task automatic test_early_read();
    MON_RXREAD = 1'b1;
    repeat (3) @(negedge CLK);
    n_checks++; if (MON_RXEMPTY !== 1'b1) begin n_fail++; $display("FAIL early_idle_empty: got %b expected 1", MON_RXEMPTY); end
    n_checks++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL early_idle_busy: got %b expected 0", BUSY); end
    build_expected(3'd0, 40'd0);
    drive_cmd(3'd0, 40'd0, 1, 1'b1, 1'b0, 0, 0);
    MON_RXREAD = 1'b0;
    n_checks++; if (got.size() !== exp.size()) begin n_fail++; $display("FAIL early_len: got %0d expected %0d", got.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      n_checks++; if (got[i] !== exp[i]) begin n_fail++; $display("FAIL early_byte%0d: got %h expected %h", i, got[i], exp[i]); end
    end
    n_checks++; if (first_ack_cyc !== 4) begin n_fail++; $display("FAIL early_ack_cycle: got %0d expected 4", first_ack_cyc); end
  endtask

  task automatic test_reset_mid();
    drive_cmd(3'd4, 40'hC00A098000, 1, 1'b0, 1'b0, 0, 5);
    RST_N = 1'b0;
    @(negedge CLK);
    n_checks++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", BUSY); end
    n_checks++; if (MON_RXEMPTY !== 1'b1) begin n_fail++; $display("FAIL midrst_empty: got %b expected 1", MON_RXEMPTY); end
    n_checks++; if (MON_RXDATA !== 8'h00) begin n_fail++; $display("FAIL midrst_data: got %h expected 00", MON_RXDATA); end
    n_checks++; if (ACK !== 1'b0 || ack_cycles !== 0) begin n_fail++; $display("FAIL midrst_ack: got %b/%0d expected 0/0", ACK, ack_cycles); end
    RST_N = 1'b1;
    @(negedge CLK);
    n_checks++; if (ACK !== 1'b0) begin n_fail++; $display("FAIL midrst_ack_after: got %b expected 0", ACK); end
    build_expected(3'd4, 40'h0123456789);
    drive_cmd(3'd4, 40'h0123456789, 2, 1'b0, 1'b0, 0, 0);
    n_checks++; if (got.size() !== exp.size()) begin n_fail++; $display("FAIL midrst_next_len: got %0d expected %0d", got.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      n_checks++; if (got[i] !== exp[i]) begin n_fail++; $display("FAIL midrst_next_byte%0d: got %h expected %h", i, got[i], exp[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] first[$];
    int first_acks;
    bit first_busy;
    drive_cmd(3'd1, 40'd0, 1, 1'b0, 1'b0, 0, 0);
    first = got; first_acks = ack_cycles; first_busy = busy_exit;
    drive_cmd(3'd3, 40'd0, 2, 1'b0, 1'b0, 0, 0);
    build_expected(3'd1, 40'd0);
    n_checks++; if (first.size() !== exp.size()) begin n_fail++; $display("FAIL b2b_first_len: got %0d expected %0d", first.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < first.size(); i++) begin
      n_checks++; if (first[i] !== exp[i]) begin n_fail++; $display("FAIL b2b_first_byte%0d: got %h expected %h", i, first[i], exp[i]); end
    end
    n_checks++; if (first_acks !== 1 || first_busy !== 1'b0) begin n_fail++; $display("FAIL b2b_first_ack: got %0d/%b expected 1/0", first_acks, first_busy); end
    build_expected(3'd3, 40'd0);
    n_checks++; if (got.size() !== exp.size()) begin n_fail++; $display("FAIL b2b_second_len: got %0d expected %0d", got.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      n_checks++; if (got[i] !== exp[i]) begin n_fail++; $display("FAIL b2b_second_byte%0d: got %h expected %h", i, got[i], exp[i]); end
    end
    n_checks++; if (ack_cycles !== 1 || timeout !== 1'b0) begin n_fail++; $display("FAIL b2b_second_ack: got %0d/%b expected 1/0", ack_cycles, timeout); end
  endtask

  task automatic test_random();
    logic [2:0]  code;
    logic [39:0] addr;
    for (int t = 0; t < 12; t++) begin
      code = 3'($urandom_range(0, 7));
      addr = {8'($urandom), 32'($urandom)};
      build_expected(code, addr);
      drive_cmd(code, addr, int'($urandom_range(1, 3)), 1'b0, 1'($urandom), 0, 0);
      n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL rand%0d_timeout: got %b expected 0", t, timeout); end
      n_checks++; if (got.size() !== exp.size()) begin n_fail++; $display("FAIL rand%0d_len: code %0d got %0d expected %0d", t, code, got.size(), exp.size()); end
      for (int i = 0; i < exp.size() && i < got.size(); i++) begin
        n_checks++; if (got[i] !== exp[i]) begin n_fail++; $display("FAIL rand%0d_byte%0d: got %h expected %h", t, i, got[i], exp[i]); end
      end
      n_checks++; if (err_pulses !== ((code > 3'd4) ? 1 : 0)) begin n_fail++; $display("FAIL rand%0d_err: code %0d got %0d pulses", t, code, err_pulses); end
      n_checks++; if (ack_cycles !== 1) begin n_fail++; $display("FAIL rand%0d_ack: got %0d expected 1", t, ack_cycles); end
    end
  endtask

  initial begin
    test_reset();
    test_status_cmd();
    test_inject();
    test_invalid();
    test_early_read();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sem_cmd_feeder.md
SEM_CMD_FEEDER -- requirements
Module: sem_cmd_feeder

Interface
REQ-001 SHALL have parameter TERM_CHAR, default 8'h0D, terminator byte appended to every command.
REQ-002 SHALL have port CLK  in  1  sole clock; all logic on the rising edge.
REQ-003 SHALL have port RST_N  in  1  reset, synchronous and active-low.
REQ-004 SHALL have port READY  in  1  command-pending level from the SEM handshake initiator.
REQ-005 SHALL have port ACK  out  1  command fully consumed; returned to the initiator.
REQ-006 SHALL have port CMD_SEL  in  3  command code, sampled on READY acceptance.
REQ-007 SHALL have port INJ_ADDR  in  40  injection linear address, sampled with CMD_SEL.
REQ-008 SHALL have port MON_RXREAD  in  1  SEM monitor byte pop strobe.
REQ-009 SHALL have port MON_RXEMPTY  out  1  high when no byte is presented to SEM.
REQ-010 SHALL have port MON_RXDATA  out  8  current command byte.
REQ-011 SHALL have port BUSY  out  1  high in any state other than IDLE.
REQ-012 SHALL have port CMD_ERR  out  1  one-cycle pulse on an invalid CMD_SEL.

Function
REQ-013 SHALL implement the states IDLE, LOAD, SEND and DONE.
REQ-014 IDLE -> LOAD when READY=1; CMD_SEL and INJ_ADDR are latched on that edge.
REQ-015 LOAD -> SEND after exactly one cycle; byte index is cleared to 0 and length is set from the latched code.
REQ-016 Codes: 0 "I", 1 "O", 2 "S", 3 "R", each followed by TERM_CHAR (length 2).
REQ-017 Code 4: "N", 8'h20, 10 upper-case hex digits of INJ_ADDR (MSB nibble first), then TERM_CHAR (length 13).
REQ-018 Hex encoding: nibble 0-9 -> 8'h30-8'h39; nibble A-F -> 8'h41-8'h46.
REQ-019 Codes 5-7: LOAD -> DONE directly, with CMD_ERR=1 for that single cycle; no byte is presented.
REQ-020 In SEND, MON_RXEMPTY=0 and MON_RXDATA=byte[index] (combinational from the registered index); in all other states MON_RXEMPTY=1 and MON_RXDATA=8'h00.
REQ-021 MON_RXREAD=1 in SEND increments the index; when it pops the last byte (index=length-1), SEND -> DONE.
REQ-022 MON_RXREAD outside SEND shall be ignored, with no state or index change.
REQ-023 In DONE, ACK=1; DONE -> IDLE on the first cycle READY=0; ACK=0 in every other state.
REQ-024 READY falling during LOAD or SEND shall be ignored: the command completes, then ACK is given; DONE exits on the first cycle it sees READY=0.
REQ-025 A new READY in IDLE on the cycle after DONE exits shall be accepted normally (back-to-back commands).
REQ-026 CMD_SEL and INJ_ADDR changes after latching shall not affect the command in progress.

Reset
REQ-027 RST_N=0 at a clock edge SHALL force IDLE, index=0, ACK=0, CMD_ERR=0, MON_RXEMPTY=1, MON_RXDATA=8'h00, BUSY=0.
REQ-028 Reset mid-SEND SHALL abandon the command without asserting ACK.

Structure
REQ-029 A shared package SHALL hold the state encoding, the command-code constants (0-4), the ASCII constants ("I","O","S","R","N", space) and the command lengths (2, 13).
REQ-030 A single sub-module sem_cmd_byte_mux SHALL map (code, index, latched address) to a byte, including the hex-to-ASCII conversion; it is purely combinational.
REQ-031 All state, the index and the latched inputs SHALL be registers in sem_cmd_feeder; there are no other sub-modules.

Verification
REQ-032 CMD_SEL=2, READY held high, MON_RXREAD pulsed every 3 cycles -> bytes 8'h53, 8'h0D presented; ACK rises the cycle after the second pop; READY low -> IDLE next cycle.
REQ-033 CMD_SEL=4, INJ_ADDR=40'hC00A098000 -> 13 bytes "N C00A098000"+8'h0D in order; exactly one ACK after the 13th pop.
REQ-034 CMD_SEL=6 -> CMD_ERR single pulse in LOAD, MON_RXEMPTY stays 1, ACK=1 the next cycle.
REQ-035 MON_RXREAD held high in IDLE, then a CMD_SEL=0 command issued -> nothing popped before SEND; in SEND one byte per cycle; DONE after 2 cycles.
REQ-036 RST_N low after 5 of 13 injection bytes -> next cycle IDLE, MON_RXEMPTY=1, no ACK; the next command starts from index 0.
REQ-037 Two commands back to back (code 1, then code 3) with READY re-asserted in the cycle after DONE exits -> both complete, each with exactly one ACK interval.
